// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the forwarding/hazard unit: stage indices,
// forwarding-select encodings and the default-sized shadow entry.
package pipe_pkg;

  localparam int AW = 5;
  localparam int TW = 2;

  localparam int ST_E = 0;
  localparam int ST_M = 1;
  localparam int ST_W = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } shadow_t;

  localparam shadow_t BUBBLE = '0;

endpackage

// File: rtl/fwd_port_sel.sv
// One read port: finds the youngest in-flight writer of the requested register,
// forwards its result when ready, otherwise flags a hazard if it arrives too late.
module fwd_port_sel #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int NSTAGE = 3
) (
  input  logic [NSTAGE-1:0]    ent_we_i,
  input  logic [NSTAGE*AW-1:0] ent_dst_i,
  input  logic [NSTAGE*TW-1:0] ent_tnew_i,
  input  logic [AW-1:0]        rd_addr_i,
  input  logic [TW-1:0]        rd_tuse_i,
  input  logic [DW-1:0]        rd_rf_i,
  input  logic [NSTAGE*DW-1:0] stage_data_i,
  output logic [DW-1:0]        fwd_data_o,
  output logic [1:0]           fwd_sel_o,
  output logic                 hazard_o
);
  import pipe_pkg::*;

  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [DW-1:0] hit_data;
  logic [1:0]    hit_sel;

  // Scan oldest to youngest so the youngest match overwrites and shadows the rest.
  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_data = '0;
    hit_sel  = FWD_RF;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (ent_we_i[s] && (ent_dst_i[s*AW +: AW] == rd_addr_i) && (rd_addr_i != '0)) begin
        hit      = 1'b1;
        hit_tnew = ent_tnew_i[s*TW +: TW];
        hit_data = stage_data_i[s*DW +: DW];
        hit_sel  = 2'(s + 1);
      end
    end
  end

  always_comb begin
    fwd_data_o = rd_rf_i;
    fwd_sel_o  = FWD_RF;
    hazard_o   = 1'b0;
    if (hit) begin
      if (hit_tnew == '0) begin
        fwd_data_o = hit_data;
        fwd_sel_o  = hit_sel;
      end else begin
        hazard_o = (hit_tnew > rd_tuse_i);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// D-stage forwarding and stall controller: a shadow pipe of in-flight register
// writes (E, M, W) with Tnew countdown, feeding one selector per read port.
module fwd_hazard_unit #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int NSTAGE = 3,
  parameter int TW     = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [AW-1:0]        issue_dst,
  input  logic [TW-1:0]        issue_tnew,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD*TW-1:0]    rd_tuse,
  input  logic [NRD*DW-1:0]    rd_rf,
  input  logic [NSTAGE*DW-1:0] stage_data,
  output logic                 stall,
  output logic [NRD*DW-1:0]    fwd_data,
  output logic [NRD*2-1:0]     fwd_sel
);
  import pipe_pkg::*;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t entry_q [NSTAGE];
  entry_t entry_d [NSTAGE];

  logic                 issue_ok;
  logic [NRD-1:0]       hazard;
  logic [NSTAGE-1:0]    ent_we;
  logic [NSTAGE*AW-1:0] ent_dst;
  logic [NSTAGE*TW-1:0] ent_tnew;

  // A stalled or flushed issue becomes a bubble; older entries keep moving.
  assign issue_ok = issue_valid & ~stall & ~flush;

  always_comb begin
    for (int s = 0; s < NSTAGE; s++) begin
      entry_d[s] = '0;
    end
    if (issue_ok) begin
      entry_d[ST_E].we   = issue_we;
      entry_d[ST_E].dst  = issue_dst;
      entry_d[ST_E].tnew = issue_tnew;
    end
    for (int s = 1; s < NSTAGE; s++) begin
      entry_d[s] = entry_q[s-1];
      if (entry_q[s-1].tnew != '0) begin
        entry_d[s].tnew = entry_q[s-1].tnew - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int s = 0; s < NSTAGE; s++) begin
      if (Reset) begin
        entry_q[s] <= '0;
      end else begin
        entry_q[s] <= entry_d[s];
      end
    end
  end

  for (genvar s = 0; s < NSTAGE; s++) begin : g_flat
    assign ent_we[s]               = entry_q[s].we;
    assign ent_dst[s*AW +: AW]     = entry_q[s].dst;
    assign ent_tnew[s*TW +: TW]    = entry_q[s].tnew;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_sel #(
      .DW     (DW),
      .AW     (AW),
      .TW     (TW),
      .NSTAGE (NSTAGE)
    ) u_sel (
      .ent_we_i     (ent_we),
      .ent_dst_i    (ent_dst),
      .ent_tnew_i   (ent_tnew),
      .rd_addr_i    (rd_addr[p*AW +: AW]),
      .rd_tuse_i    (rd_tuse[p*TW +: TW]),
      .rd_rf_i      (rd_rf[p*DW +: DW]),
      .stage_data_i (stage_data),
      .fwd_data_o   (fwd_data[p*DW +: DW]),
      .fwd_sel_o    (fwd_sel[p*2 +: 2]),
      .hazard_o     (hazard[p])
    );
  end

  assign stall = |hazard;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios followed by random
// traffic, all checked against an in-flight instruction history model.
module tb_fwd_hazard_unit;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int NSTAGE = 3;
  localparam int TW     = 2;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 issue_valid;
  logic                 issue_we;
  logic [AW-1:0]        issue_dst;
  logic [TW-1:0]        issue_tnew;
  logic                 flush;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*TW-1:0]    rd_tuse;
  logic [NRD*DW-1:0]    rd_rf;
  logic [NSTAGE*DW-1:0] stage_data;
  logic                 stall;
  logic [NRD*DW-1:0]    fwd_data;
  logic [NRD*2-1:0]     fwd_sel;

  always #5 Clk = ~Clk;

  fwd_hazard_unit #(
    .DW(DW), .AW(AW), .NRD(NRD), .NSTAGE(NSTAGE), .TW(TW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_dst   (issue_dst),
    .issue_tnew  (issue_tnew),
    .flush       (flush),
    .rd_addr     (rd_addr),
    .rd_tuse     (rd_tuse),
    .rd_rf       (rd_rf),
    .stage_data  (stage_data),
    .stall       (stall),
    .fwd_data    (fwd_data),
    .fwd_sel     (fwd_sel)
  );

  // History of what entered E on each past cycle; index i has been in flight i cycles.
  typedef struct {
    bit we;
    int dst;
    int tnew;
  } rec_t;

  rec_t hist_q[$];
  bit   model_ok = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic void model_port(input int p, output logic [1:0] sel,
                                     output logic [DW-1:0] data, output bit haz);
    int addr, tuse, rem;
    addr = int'(rd_addr[p*AW +: AW]);
    tuse = int'(rd_tuse[p*TW +: TW]);
    sel  = 2'd0;
    data = rd_rf[p*DW +: DW];
    haz  = 1'b0;
    for (int i = 0; i < hist_q.size(); i++) begin
      if (hist_q[i].we && hist_q[i].dst == addr && addr != 0) begin
        rem = hist_q[i].tnew - i;
        if (rem < 0) rem = 0;
        if (rem == 0) begin
          sel  = 2'(i + 1);
          data = stage_data[i*DW +: DW];
        end else begin
          haz = (rem > tuse);
        end
        break;
      end
    end
  endfunction

  function automatic bit model_stall();
    logic [1:0]    s;
    logic [DW-1:0] d;
    bit            h;
    bit            any;
    any = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      model_port(p, s, d, h);
      any = any | h;
    end
    return any;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [1:0]    s;
    logic [DW-1:0] d;
    bit            h;
    #1;
    if (model_ok) begin
      check("stall", 64'(stall), 64'(model_stall()));
      for (int p = 0; p < NRD; p++) begin
        model_port(p, s, d, h);
        check($sformatf("fwd_sel%0d", p), 64'(fwd_sel[p*2 +: 2]), 64'(s));
        check($sformatf("fwd_data%0d", p), 64'(fwd_data[p*DW +: DW]), 64'(d));
      end
    end
  endtask

  task automatic tick();
    rec_t r;
    bit   st;
    @(posedge Clk);
    st = model_stall();
    if (Reset) begin
      hist_q.delete();
      r.we = 0; r.dst = 0; r.tnew = 0;
      for (int i = 0; i < NSTAGE; i++) hist_q.push_back(r);
      model_ok = 1;
    end else if (model_ok) begin
      r.we = 0; r.dst = 0; r.tnew = 0;
      if (issue_valid && !st && !flush) begin
        r.we = issue_we; r.dst = int'(issue_dst); r.tnew = int'(issue_tnew);
      end
      hist_q.push_front(r);
      void'(hist_q.pop_back());
    end
    @(negedge Clk);
  endtask

  task automatic drv(input bit iv, input bit we, input int dst, input int tnew, input bit fl,
                     input int a0, input int t0, input int a1, input int t1);
    issue_valid = iv;
    issue_we    = we;
    issue_dst   = AW'(dst);
    issue_tnew  = TW'(tnew);
    flush       = fl;
    rd_addr     = {AW'(a1), AW'(a0)};
    rd_tuse     = {TW'(t1), TW'(t0)};
    for (int p = 0; p < NRD; p++) rd_rf[p*DW +: DW] = $urandom;
    for (int s = 0; s < NSTAGE; s++) stage_data[s*DW +: DW] = $urandom;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with random inputs: outputs must stay neutral.
    for (int c = 0; c < 4; c++) begin
      drv($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3));
      settle();
      if (c > 0) begin
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_sel", 64'(fwd_sel), 64'(0));
        check("rst_data", 64'(fwd_data), 64'(rd_rf));
      end
      tick();
    end
    Reset = 1'b0;

    // addu $8 with tnew=0 walks E -> M -> W -> gone.
    drv(1, 1, 8, 0, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 8, 0, 0, 0);
    stage_data[31:0] = 32'h1234;
    settle();
    check("addu_e_sel", 64'(fwd_sel[1:0]), 64'(1));
    check("addu_e_data", 64'(fwd_data[31:0]), 64'h1234);
    check("addu_e_stall", 64'(stall), 64'(0));
    tick();
    drv(0, 0, 0, 0, 0, 8, 0, 0, 0); settle();
    check("addu_m_sel", 64'(fwd_sel[1:0]), 64'(2));
    tick();
    drv(0, 0, 0, 0, 0, 8, 0, 0, 0); settle();
    check("addu_w_sel", 64'(fwd_sel[1:0]), 64'(3));
    tick();
    drv(0, 0, 0, 0, 0, 8, 0, 0, 0); settle();
    check("addu_gone_sel", 64'(fwd_sel[1:0]), 64'(0));
    tick();

    // lw $9 (tnew=2), consumer needs it immediately: two stall cycles then W forward.
    drv(1, 1, 9, 2, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    check("lw_stall_e", 64'(stall), 64'(1));
    tick();
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    check("lw_stall_m", 64'(stall), 64'(1));
    tick();
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    check("lw_w_stall", 64'(stall), 64'(0));
    check("lw_w_sel", 64'(fwd_sel[1:0]), 64'(3));
    tick();

    // Same load with tuse=1: exactly one stall cycle.
    drv(1, 1, 9, 2, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 9, 1, 0, 0); settle();
    check("lw1_stall_e", 64'(stall), 64'(1));
    tick();
    drv(0, 0, 0, 0, 0, 9, 1, 0, 0); settle();
    check("lw1_stall_m", 64'(stall), 64'(0));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Two writers of $5: the younger (E) shadows the older (M).
    drv(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    drv(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 5, 0);
    stage_data[31:0]  = 32'hA;
    stage_data[63:32] = 32'hB;
    settle();
    check("dup_data1", 64'(fwd_data[63:32]), 64'hA);
    check("dup_sel1", 64'(fwd_sel[3:2]), 64'(1));
    tick();

    // Writes to $0 never forward; a flushed issue leaves no trace.
    drv(1, 1, 0, 3, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 3, 0, 0); settle();
    check("r0_sel", 64'(fwd_sel), 64'(0));
    check("r0_stall", 64'(stall), 64'(0));
    check("r0_data", 64'(fwd_data), 64'(rd_rf));
    tick();
    drv(1, 1, 7, 0, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 7, 0, 0, 0); settle();
    check("flush_sel", 64'(fwd_sel[1:0]), 64'(0));
    tick();

    // Issue during a stall is dropped.
    drv(1, 1, 9, 2, 0, 0, 0, 0, 0); step();
    drv(1, 1, 10, 0, 0, 9, 0, 0, 0); settle();
    check("drop_stall", 64'(stall), 64'(1));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 10, 0); settle();
    check("drop_sel1", 64'(fwd_sel[3:2]), 64'(0));
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset mid-stall clears every entry.
    drv(1, 1, 9, 2, 0, 0, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 9, 0, 0, 0); settle();
    check("rstmid_stall", 64'(stall), 64'(1));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drv(0, 0, 0, 0, 0, 9, 0, 9, 0); settle();
    check("rstmid_after_stall", 64'(stall), 64'(0));
    check("rstmid_after_sel", 64'(fwd_sel), 64'(0));
    tick();

    // Random traffic over a small register window to provoke hits and hazards.
    for (int c = 0; c < 400; c++) begin
      Reset = ($urandom_range(0, 49) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4),
          $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 4),
          $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
      step();
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
